// File: rtl/serial_subtractor_nbit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_nbit
//
// Purpose:
//   Bit-serial unsigned N-bit subtractor. Computes diff = (a - b) mod 2^N one
//   bit per clock, LSB first, and reports the final borrow (1 iff a < b).
//   This is the serial counterpart of the combinational N-bit adder. It trades
//   N cycles of latency for a single full-subtractor cell.
//
// Handshake (valid/ready in one sentence):
//   start is honoured only in IDLE (busy=0, done=0). a/b are sampled on the
//   edge that accepts start. busy is high for the N processing cycles. done
//   pulses for exactly one cycle when diff/borrowout hold the new result.
//   start seen while busy or done is dropped, not queued.
//
// Timing:
//   start is accepted at edge E0. Bits 0..N-1 are processed at edges E1..EN.
//   done is high in the cycle after EN. The start-to-start interval is N+2
//   cycles.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   start      in   1  begin a subtraction (IDLE only)
//   a          in   N  minuend
//   b          in   N  subtrahend
//   busy       out  1  subtraction in progress
//   done       out  1  one-cycle result-valid pulse
//   diff       out  N  (a - b) mod 2^N, held until the next completion
//   borrowout  out  1  final borrow, held until the next completion
// -----------------------------------------------------------------------------
module serial_subtractor_nbit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrowout
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_sh_q, a_sh_d;
    logic [N-1:0]   b_sh_q, b_sh_d;
    logic [N-1:0]   res_q, res_d;
    logic [N-1:0]   diff_q, diff_d;
    logic           br_q, br_d;
    logic           borrowout_q, borrowout_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Full-subtractor cell operating on the current LSBs of the shift registers
    logic bit_a;
    logic bit_b;
    logic bit_d;
    logic bit_br;
    logic last_bit;

    always_comb begin
        bit_a    = a_sh_q[0];
        bit_b    = b_sh_q[0];
        bit_d    = bit_a ^ bit_b ^ br_q;
        bit_br   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        last_bit = (cnt_q == CW'(N - 1));
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        diff_d      = diff_q;
        br_d        = br_q;
        borrowout_d = borrowout_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // Operands shift right so bit i is always at position 0.
                // Result bits enter from the MSB side, so after N shifts
                // bit 0 has reached the LSB.
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {bit_d, res_q[N-1:1]};
                br_d   = bit_br;
                cnt_d  = cnt_q + 1'b1;
                if (last_bit) begin
                    // Publish the completed word directly. The visible
                    // outputs therefore never show a partial result.
                    diff_d      = {bit_d, res_q[N-1:1]};
                    borrowout_d = bit_br;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            diff_q      <= '0;
            br_q        <= 1'b0;
            borrowout_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            diff_q      <= diff_d;
            br_q        <= br_d;
            borrowout_q <= borrowout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign diff      = diff_q;
    assign borrowout = borrowout_q;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
module tb_serial_subtractor_nbit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N=4 instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, bo4;
  logic [3:0] diff4;

  // N=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;

  serial_subtractor_nbit #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrowout(bo4)
  );

  serial_subtractor_nbit #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrowout(bo8)
  );

  int total = 0;
  int bad = 0;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue one N=4 subtraction, wait (bounded) for done, check the result.
  task automatic run4(input logic [3:0] av, input logic [3:0] bv,
                      input logic [3:0] ed, input logic eb, input string tag);
    int i;
    @(negedge clk);
    start4 = 1'b1; a4 = av; b4 = bv;
    @(negedge clk);
    start4 = 1'b0;
    i = 0;
    while (!done4 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done"}, {31'b0, done4}, 32'd1);
    chk({tag, "_diff"}, {28'b0, diff4}, {28'b0, ed});
    chk({tag, "_bo"}, {31'b0, bo4}, {31'b0, eb});
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb, input string tag);
    int i;
    @(negedge clk);
    start8 = 1'b1; a8 = av; b8 = bv;
    @(negedge clk);
    start8 = 1'b0;
    i = 0;
    while (!done8 && i < 30) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done"}, {31'b0, done8}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy8}, 32'd0);
    chk({tag, "_diff"}, {24'b0, diff8}, {24'b0, ed});
    chk({tag, "_bo"}, {31'b0, bo8}, {31'b0, eb});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int nbusy;
    int ndone;
    int i;
    logic [7:0] ra, rb;

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy4}, 32'd0);
    chk("rst_done", {31'b0, done4}, 32'd0);
    chk("rst_diff", {28'b0, diff4}, 32'd0);
    chk("rst_bo", {31'b0, bo4}, 32'd0);
    rst = 1'b0;

    // 9 - 3: busy exactly 4 cycles, then a one-cycle done
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    @(negedge clk);
    start4 = 1'b0;
    nbusy = 0;
    i = 0;
    while (busy4 && i < 20) begin
      nbusy++;
      @(negedge clk);
      i++;
    end
    chk("lat_busy_cycles", nbusy, 32'd4);
    chk("lat_done", {31'b0, done4}, 32'd1);
    chk("9m3_diff", {28'b0, diff4}, 32'd6);
    chk("9m3_bo", {31'b0, bo4}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done4}, 32'd0);
    chk("hold_diff_idle", {28'b0, diff4}, 32'd6);

    // hand-computed corners
    run4(4'd3, 4'd9, 4'hA, 1'b1, "3m9");
    run4(4'd0, 4'd1, 4'hF, 1'b1, "0m1");
    run4(4'd15, 4'd15, 4'h0, 1'b0, "15m15");
    run4(4'd0, 4'd15, 4'h1, 1'b1, "0m15");

    // start/a/b disturbed mid-operation: must not affect result or re-trigger
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd5;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd2;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 3) start4 = 1'b0;
      if (done4) begin
        ndone++;
        chk("intf_diff", {28'b0, diff4}, 32'd7);
        chk("intf_bo", {31'b0, bo4}, 32'd0);
      end
    end
    chk("intf_ndone", ndone, 32'd1);
    chk("intf_idle", {31'b0, busy4}, 32'd0);

    // reset during the 2nd SHIFT cycle
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd8; b4 = 4'd1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy4}, 32'd0);
    chk("midrst_done", {31'b0, done4}, 32'd0);
    chk("midrst_diff", {28'b0, diff4}, 32'd0);
    chk("midrst_bo", {31'b0, bo4}, 32'd0);
    rst = 1'b0;
    run4(4'd8, 4'd1, 4'd7, 1'b0, "after_rst");

    // start held high: done every 6 cycles, outputs held between pulses
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd6; b4 = 4'd2;
    i = 0;
    while (!done4 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("held_first_done", {31'b0, done4}, 32'd1);
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k < 6; k++) begin
        @(negedge clk);
        chk("held_gap_done", {31'b0, done4}, 32'd0);
        chk("held_gap_diff", {28'b0, diff4}, 32'd4);
      end
      @(negedge clk);
      chk("held_period_done", {31'b0, done4}, 32'd1);
      chk("held_period_diff", {28'b0, diff4}, 32'd4);
    end
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("held_stop_busy", {31'b0, busy4}, 32'd0);

    // exhaustive N=4 sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run4(ia[3:0], ib[3:0], 4'(ia - ib), (ia < ib), "sweep4");
      end
    end

    // N=8: corners then random pairs
    run8(8'd0, 8'd255, 8'd1, 1'b1, "n8_0m255");
    run8(8'd200, 8'd200, 8'd0, 1'b0, "n8_eq");
    run8(8'd200, 8'd55, 8'd145, 1'b0, "n8_200m55");
    for (int k = 0; k < 100; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run8(ra, rb, ra - rb, (ra < rb), "rand8");
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_nbit.md
Name: serial_subtractor_nbit

Overview:
- Bit-serial, unsigned N-bit subtractor: the inverse operation of the combinational N-bit adder.
- Computes a - b one bit per clock, LSB first, under a start/busy/done handshake.
- Reports the difference and a borrow-out flag.
- Sits beside the adder in the arithmetic library as an area-cheap datapath element.
- Its result is checked against the same exhaustive operand sweep as the adder.

Parameters:
N, 4, operand and result width in bits (N >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request to begin a subtraction; honoured only in IDLE
a  input  N  minuend; sampled on the edge that accepts start
b  input  N  subtrahend; sampled on the edge that accepts start
busy  output  1  high while a subtraction is in progress
done  output  1  single-cycle pulse: diff and borrowout are valid
diff  output  N  result a - b modulo 2^N
borrowout  output  1  final borrow; 1 iff a < b (unsigned)

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: on any edge with rst=1, state=IDLE, busy=0, done=0, diff=0, borrowout=0, bit counter=0, internal borrow=0.
  - Reset overrides start and applies at any point mid-operation; a partial result is discarded.
- States: IDLE, SHIFT, DONE.
  - IDLE: busy=0, done=0.
    - On an edge with start=1: capture a and b into shift registers, clear the internal borrow, set counter=0, go to SHIFT.
  - SHIFT: busy=1, done=0. Each edge processes bit i = counter:
    - d = a[i] ^ b[i] ^ br
    - br_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br)
    - d is shifted into the result register from the MSB side; counter increments.
    - On the edge that processes bit N-1, go to DONE.
    - At the same edge, load diff with the completed result and borrowout with br_next.
  - DONE: busy=0, done=1 for exactly one cycle; the next edge returns to IDLE.
- Latency: start accepted at edge E0; bits are processed at edges E1..EN; done is high in the cycle after EN.
  - Issue interval: N+2 cycles (start-to-start).
- diff and borrowout change only at the completing edge or on reset. They hold their value through IDLE until the next result completes.
- start while busy=1 or done=1 is ignored; it is neither queued nor allowed to corrupt the operation.
- Holding start high continuously re-triggers on each IDLE visit, giving back-to-back operations every N+2 cycles.
- Changes on a/b after the accepting edge do not affect the operation in progress.
- Arithmetic rules:
  - Unsigned. diff = (a - b) mod 2^N.
  - a == b gives diff=0, borrowout=0.
  - a=0, b=2^N-1 gives diff=1, borrowout=1.
- No X propagation: the outputs are defined at all times after the first reset edge.

Test Plan:
- N=4, reset then start with a=9, b=3 -> busy for 4 cycles, then done pulse; diff=6, borrowout=0.
- a=3, b=9 -> diff=10 (4'hA), borrowout=1; a=0, b=1 -> diff=15, borrowout=1; a=15, b=15 -> diff=0, borrowout=0.
- Start a=12, b=5; at cycle 2 drive start=1 with a=1, b=2 and change the a/b pins -> first result unaffected (diff=7, borrowout=0); second start ignored; single done pulse.
- Start a=8, b=1; assert rst at the 2nd SHIFT cycle -> next cycle busy=0, done=0, diff=0, borrowout=0; a subsequent start with a=8, b=1 yields diff=7.
- start held high -> done pulses every 6 cycles; outputs hold between pulses.
- Exhaustive sweep over all 256 (a,b) pairs, each wait on done -> diff == (a-b)&15 and borrowout == (a<b); repeat the sweep with N=8 on random pairs.
